// File: rtl/sort_check_monitor_if.sv
// Bus between the run monitor and the CPU/data-memory side: CPU observation
// inputs, the data-memory read port, and the verdict outputs.
interface sort_check_monitor_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned IDX_W  = 4
);
   logic [ADDR_W-1:0] pc;
   logic              overflow;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              done;
   logic              pass;
   logic [1:0]        err_code;
   logic [IDX_W-1:0]  bad_index;
   logic [31:0]       cycle_count;

   modport master (
      input  pc, overflow, mem_rd_data,
      output mem_rd_en, mem_addr, done, pass, err_code, bad_index, cycle_count
   );

   modport slave (
      output pc, overflow, mem_rd_data,
      input  mem_rd_en, mem_addr, done, pass, err_code, bad_index, cycle_count
   );
endinterface

// File: rtl/sort_check_monitor.sv
// End-of-run monitor: waits for the stop PC, scans an array region out of data
// memory, checks neighbour ordering and reports a sticky pass/fail verdict.
module sort_check_monitor #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned BASE_ADDR  = 512,
   parameter int unsigned N          = 12,
   parameter int unsigned STOP_PC    = 104,
   parameter int unsigned EXPECT_OVF = 1,
   parameter int unsigned DESCENDING = 0,
   parameter int unsigned STRICT     = 1,
   parameter int unsigned SIGNED     = 1
) (
   input logic                 clk,
   input logic                 rst,
   sort_check_monitor_if.master bus
);
   localparam int unsigned IDX_W = $clog2(N + 1);

   typedef enum logic [1:0] {RUN = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   state_t            state_r, state_s;
   logic [31:0]       cnt_r, cnt_s;
   logic [1:0]        err_r, err_s;
   logic [IDX_W-1:0]  bad_r, bad_s;
   logic [IDX_W-1:0]  rd_idx_r, rd_idx_s;
   logic [IDX_W-1:0]  ret_idx_r, ret_idx_s;
   logic              en_r, en_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              vld_r, vld_s;
   logic [DATA_W-1:0] prev_r, prev_s;
   logic              done_r, done_s;
   logic              pass_r, pass_s;

   // 1 when the pair (a = earlier, b = later) breaks the configured ordering
   function automatic logic order_violation(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
      logic lt_s, gt_s, eq_s, ok_s;
      eq_s = (a == b);
      if (SIGNED != 0) begin
         lt_s = ($signed(a) < $signed(b));
         gt_s = ($signed(a) > $signed(b));
      end else begin
         lt_s = (a < b);
         gt_s = (a > b);
      end
      if (DESCENDING != 0) begin
         ok_s = gt_s || ((STRICT == 0) && eq_s);
      end else begin
         ok_s = lt_s || ((STRICT == 0) && eq_s);
      end
      return !ok_s;
   endfunction

   // next-state and next-value logic for the RUN/SCAN/DONE sequence
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      err_s     = err_r;
      bad_s     = bad_r;
      rd_idx_s  = rd_idx_r;
      ret_idx_s = ret_idx_r;
      en_s      = 1'b0;
      addr_s    = addr_r;
      vld_s     = en_r;
      prev_s    = prev_r;
      done_s    = done_r;
      pass_s    = pass_r;
      case (state_r)
         RUN: begin
            cnt_s = cnt_r + 32'd1;
            // stop PC wins over a simultaneous overflow
            if (bus.pc == ADDR_W'(STOP_PC)) begin
               state_s   = SCAN;
               en_s      = 1'b1;
               addr_s    = ADDR_W'(BASE_ADDR);
               rd_idx_s  = IDX_W'(1);
               ret_idx_s = '0;
               if ((EXPECT_OVF != 0) && !bus.overflow) begin
                  err_s = 2'd2;
               end else begin
                  err_s = err_r;
               end
            end else if (bus.overflow) begin
               state_s = DONE;
               err_s   = 2'd1;
               done_s  = 1'b1;
               pass_s  = 1'b0;
            end else begin
               state_s = RUN;
            end
         end
         SCAN: begin
            if (rd_idx_r < IDX_W'(N)) begin
               en_s     = 1'b1;
               addr_s   = ADDR_W'(BASE_ADDR) + (ADDR_W'(rd_idx_r) << 2);
               rd_idx_s = rd_idx_r + IDX_W'(1);
            end else begin
               en_s = 1'b0;
            end
            // data word in flight this cycle belongs to element ret_idx_r
            if (vld_r) begin
               prev_s    = bus.mem_rd_data;
               ret_idx_s = ret_idx_r + IDX_W'(1);
               if ((ret_idx_r != '0) && (bad_r == '0) &&
                   order_violation(prev_r, bus.mem_rd_data)) begin
                  bad_s = ret_idx_r;
                  if (err_r == 2'd0) begin
                     err_s = 2'd3;
                  end else begin
                     err_s = err_r;
                  end
               end else begin
                  bad_s = bad_r;
               end
               if (ret_idx_r == IDX_W'(N - 1)) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                  pass_s  = (err_s == 2'd0);
               end else begin
                  state_s = SCAN;
               end
            end else begin
               state_s = SCAN;
            end
         end
         DONE: begin
            state_s = DONE;
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // state and datapath registers; rst returns everything to the idle run
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= RUN;
         cnt_r     <= 32'd0;
         err_r     <= 2'd0;
         bad_r     <= '0;
         rd_idx_r  <= '0;
         ret_idx_r <= '0;
         en_r      <= 1'b0;
         addr_r    <= '0;
         vld_r     <= 1'b0;
         prev_r    <= '0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         err_r     <= err_s;
         bad_r     <= bad_s;
         rd_idx_r  <= rd_idx_s;
         ret_idx_r <= ret_idx_s;
         en_r      <= en_s;
         addr_r    <= addr_s;
         vld_r     <= vld_s;
         prev_r    <= prev_s;
         done_r    <= done_s;
         pass_r    <= pass_s;
      end
   end

   assign bus.mem_rd_en   = en_r;
   assign bus.mem_addr    = addr_r;
   assign bus.done        = done_r;
   assign bus.pass        = pass_r;
   assign bus.err_code    = err_r;
   assign bus.bad_index   = bad_r;
   assign bus.cycle_count = cnt_r;
endmodule

// File: tb/tb_sort_check_monitor.sv
// Bench for sort_check_monitor: a default instance plus two descending N=4
// instances, each with its own data-memory model, driven by a shared PC stream.
module tb_sort_check_monitor;
   localparam int N0   = 12;
   localparam int IDX0 = $clog2(N0 + 1);
   localparam int IDX1 = $clog2(4 + 1);

   typedef struct {
      int err;
      int pass;
      int bad;
      int cnt;
      int lat;
   } res_t;

   typedef struct {
      logic [31:0] addr;
      int          stamp;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc  = 32'd0;
   logic        ovf = 1'b0;
   int          tick = 0;
   int          n_cmp = 0;
   int          n_mis = 0;

   logic [31:0] mem0 [N0];
   int raw_a [N0] = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
   int srt_a [N0] = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
   int dsc_a [4]  = '{5, 5, -3, -7};

   res_t        exp_res_q[$];
   logic [31:0] exp_addr_q[$];
   rd_t         obs_q[$];

   sort_check_monitor_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(IDX0)) bus0();
   sort_check_monitor_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(IDX1)) bus_s();
   sort_check_monitor_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(IDX1)) bus_u();

   assign bus0.pc = pc;   assign bus0.overflow = ovf;
   assign bus_s.pc = pc;  assign bus_s.overflow = ovf;
   assign bus_u.pc = pc;  assign bus_u.overflow = ovf;

   sort_check_monitor dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
   sort_check_monitor #(.N(4), .DESCENDING(1), .STRICT(0), .SIGNED(1))
      dut_s (.clk(clk), .rst(rst), .bus(bus_s.master));
   sort_check_monitor #(.N(4), .DESCENDING(1), .STRICT(0), .SIGNED(0))
      dut_u (.clk(clk), .rst(rst), .bus(bus_u.master));

   always #5 clk = ~clk;

   always @(posedge clk) tick <= tick + 1;

   wire [31:0] a0 = (bus0.mem_addr - 32'd512) >> 2;
   wire [31:0] as = (bus_s.mem_addr - 32'd512) >> 2;
   wire [31:0] au = (bus_u.mem_addr - 32'd512) >> 2;

   // data memories: word returned one cycle after the read strobe
   always @(posedge clk) begin
      if (bus0.mem_rd_en === 1'b1)
         bus0.mem_rd_data <= (a0 < 32'd12) ? mem0[a0[3:0]] : 32'hDEADBEEF;
      if (bus_s.mem_rd_en === 1'b1)
         bus_s.mem_rd_data <= (as < 32'd4) ? 32'(dsc_a[as[1:0]]) : 32'hDEADBEEF;
      if (bus_u.mem_rd_en === 1'b1)
         bus_u.mem_rd_data <= (au < 32'd4) ? 32'(dsc_a[au[1:0]]) : 32'hDEADBEEF;
   end

   always @(negedge clk) begin
      if (bus0.mem_rd_en === 1'b1) obs_q.push_back('{bus0.mem_addr, tick});
   end

   task automatic load_mem(input bit sorted);
      for (int k = 0; k < N0; k++) mem0[k] = sorted ? 32'(srt_a[k]) : 32'(raw_a[k]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pc = 32'd0; ovf = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
   endtask

   // walk pc 0,4,..,last; overflow only on the last step; ends at negedge after the trigger
   task automatic drive_pc(input int last, input bit ovf_last);
      for (int p = 0; p <= last; p += 4) begin
         pc  = 32'(p);
         ovf = (p == last) ? ovf_last : 1'b0;
         @(negedge clk);
      end
      pc  = 32'(last + 4);
      ovf = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (bus0.done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic push_reads();
      for (int k = 0; k < N0; k++) exp_addr_q.push_back(32'(512 + 4 * k));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus0.done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %0b want 0", bus0.done); end
      n_cmp++; if (bus0.pass !== 1'b0) begin n_mis++; $display("FAIL reset_pass got %0b want 0", bus0.pass); end
      n_cmp++; if (bus0.err_code !== 2'd0) begin n_mis++; $display("FAIL reset_err got %0d want 0", bus0.err_code); end
      n_cmp++; if (bus0.bad_index !== 4'd0) begin n_mis++; $display("FAIL reset_bad got %0d want 0", bus0.bad_index); end
      n_cmp++; if (bus0.cycle_count !== 32'd0) begin n_mis++; $display("FAIL reset_cnt got %0d want 0", bus0.cycle_count); end
      n_cmp++; if (bus0.mem_rd_en !== 1'b0) begin n_mis++; $display("FAIL reset_en got %0b want 0", bus0.mem_rd_en); end
      n_cmp++; if (bus0.mem_addr !== 32'd0) begin n_mis++; $display("FAIL reset_addr got %0d want 0", bus0.mem_addr); end
   endtask

   task automatic test_sorted();
      res_t e; rd_t o; logic [31:0] ea; int lat; int first;
      load_mem(1'b1);
      do_reset();
      exp_res_q.push_back('{0, 1, 0, 27, N0 + 2});
      push_reads();
      drive_pc(104, 1'b1);
      wait_done(lat);
      e = exp_res_q.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_mis++; $display("FAIL sorted_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (int'(bus0.err_code) !== e.err) begin n_mis++; $display("FAIL sorted_err got %0d want %0d", bus0.err_code, e.err); end
      n_cmp++; if (int'(bus0.pass) !== e.pass) begin n_mis++; $display("FAIL sorted_pass got %0d want %0d", bus0.pass, e.pass); end
      n_cmp++; if (int'(bus0.bad_index) !== e.bad) begin n_mis++; $display("FAIL sorted_bad got %0d want %0d", bus0.bad_index, e.bad); end
      n_cmp++; if (int'(bus0.cycle_count) !== e.cnt) begin n_mis++; $display("FAIL sorted_cnt got %0d want %0d", bus0.cycle_count, e.cnt); end
      n_cmp++; if (obs_q.size() !== exp_addr_q.size()) begin n_mis++; $display("FAIL sorted_nreads got %0d want %0d", obs_q.size(), exp_addr_q.size()); end
      first = (obs_q.size() > 0) ? obs_q[0].stamp : 0;
      for (int k = 0; exp_addr_q.size() > 0 && obs_q.size() > 0; k++) begin
         ea = exp_addr_q.pop_front();
         o  = obs_q.pop_front();
         n_cmp++; if (o.addr !== ea) begin n_mis++; $display("FAIL sorted_read_addr[%0d] got %0d want %0d", k, o.addr, ea); end
         n_cmp++; if (o.stamp !== first + k) begin n_mis++; $display("FAIL sorted_read_cycle[%0d] got %0d want %0d", k, o.stamp, first + k); end
      end
      exp_addr_q.delete();
      // pc/overflow are ignored once done
      for (int k = 0; k < 5; k++) begin
         pc = 32'd104; ovf = k[0];
         @(negedge clk);
      end
      ovf = 1'b0;
      n_cmp++; if (bus0.cycle_count !== 32'd27) begin n_mis++; $display("FAIL sorted_cnt_frozen got %0d want 27", bus0.cycle_count); end
      n_cmp++; if (bus0.done !== 1'b1) begin n_mis++; $display("FAIL sorted_done_sticky got %0b want 1", bus0.done); end
      n_cmp++; if (obs_q.size() !== 0) begin n_mis++; $display("FAIL sorted_extra_reads got %0d want 0", obs_q.size()); end
      n_cmp++; if (bus_s.pass !== 1'b1 || bus_s.err_code !== 2'd0 || bus_s.done !== 1'b1) begin n_mis++; $display("FAIL desc_signed got pass=%0b err=%0d done=%0b want pass=1 err=0 done=1", bus_s.pass, bus_s.err_code, bus_s.done); end
      n_cmp++; if (bus_u.err_code !== 2'd3 || bus_u.pass !== 1'b0) begin n_mis++; $display("FAIL desc_unsigned_err got err=%0d pass=%0b want err=3 pass=0", bus_u.err_code, bus_u.pass); end
      n_cmp++; if (bus_u.bad_index !== 3'd2) begin n_mis++; $display("FAIL desc_unsigned_bad got %0d want 2", bus_u.bad_index); end
   endtask

   task automatic test_unsorted();
      res_t e; int lat;
      load_mem(1'b0);
      do_reset();
      exp_res_q.push_back('{3, 0, 2, 27, N0 + 2});
      drive_pc(104, 1'b1);
      wait_done(lat);
      e = exp_res_q.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_mis++; $display("FAIL unsorted_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (int'(bus0.err_code) !== e.err) begin n_mis++; $display("FAIL unsorted_err got %0d want %0d", bus0.err_code, e.err); end
      n_cmp++; if (int'(bus0.pass) !== e.pass) begin n_mis++; $display("FAIL unsorted_pass got %0d want %0d", bus0.pass, e.pass); end
      n_cmp++; if (int'(bus0.bad_index) !== e.bad) begin n_mis++; $display("FAIL unsorted_bad got %0d want %0d", bus0.bad_index, e.bad); end
      n_cmp++; if (obs_q.size() !== N0) begin n_mis++; $display("FAIL unsorted_nreads got %0d want %0d", obs_q.size(), N0); end
   endtask

   task automatic test_overflow();
      res_t e; int lat;
      load_mem(1'b1);
      do_reset();
      exp_res_q.push_back('{1, 0, 0, 11, 1});
      drive_pc(40, 1'b1);
      wait_done(lat);
      e = exp_res_q.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_mis++; $display("FAIL ovf_latency got %0d want %0d", lat, e.lat); end
      for (int p = 44; p <= 120; p += 4) begin
         pc = 32'(p);
         @(negedge clk);
      end
      n_cmp++; if (int'(bus0.err_code) !== e.err) begin n_mis++; $display("FAIL ovf_err got %0d want %0d", bus0.err_code, e.err); end
      n_cmp++; if (int'(bus0.pass) !== e.pass) begin n_mis++; $display("FAIL ovf_pass got %0d want %0d", bus0.pass, e.pass); end
      n_cmp++; if (int'(bus0.cycle_count) !== e.cnt) begin n_mis++; $display("FAIL ovf_cnt got %0d want %0d", bus0.cycle_count, e.cnt); end
      n_cmp++; if (obs_q.size() !== 0) begin n_mis++; $display("FAIL ovf_reads got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_missing_ovf();
      res_t e; int lat;
      for (int s = 1; s >= 0; s--) begin
         load_mem(s[0]);
         do_reset();
         exp_res_q.push_back('{2, 0, (s == 1) ? 0 : 2, 27, N0 + 2});
         drive_pc(104, 1'b0);
         wait_done(lat);
         e = exp_res_q.pop_front();
         n_cmp++; if (lat !== e.lat) begin n_mis++; $display("FAIL missing_latency[%0d] got %0d want %0d", s, lat, e.lat); end
         n_cmp++; if (int'(bus0.err_code) !== e.err) begin n_mis++; $display("FAIL missing_err[%0d] got %0d want %0d", s, bus0.err_code, e.err); end
         n_cmp++; if (int'(bus0.pass) !== e.pass) begin n_mis++; $display("FAIL missing_pass[%0d] got %0d want %0d", s, bus0.pass, e.pass); end
         n_cmp++; if (int'(bus0.bad_index) !== e.bad) begin n_mis++; $display("FAIL missing_bad[%0d] got %0d want %0d", s, bus0.bad_index, e.bad); end
      end
   endtask

   task automatic test_reset_mid_scan();
      res_t e; rd_t o; logic [31:0] ea; int lat; int first;
      load_mem(1'b1);
      do_reset();
      drive_pc(104, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus0.mem_rd_en !== 1'b0) begin n_mis++; $display("FAIL midrst_en got %0b want 0", bus0.mem_rd_en); end
      n_cmp++; if (bus0.mem_addr !== 32'd0) begin n_mis++; $display("FAIL midrst_addr got %0d want 0", bus0.mem_addr); end
      n_cmp++; if (bus0.cycle_count !== 32'd0) begin n_mis++; $display("FAIL midrst_cnt got %0d want 0", bus0.cycle_count); end
      n_cmp++; if (bus0.done !== 1'b0 || bus0.err_code !== 2'd0 || bus0.bad_index !== 4'd0 || bus0.pass !== 1'b0) begin n_mis++; $display("FAIL midrst_outputs got done=%0b err=%0d bad=%0d pass=%0b want all 0", bus0.done, bus0.err_code, bus0.bad_index, bus0.pass); end
      rst = 1'b0;
      obs_q.delete();
      exp_res_q.push_back('{0, 1, 0, 27, N0 + 2});
      push_reads();
      drive_pc(104, 1'b1);
      wait_done(lat);
      e = exp_res_q.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_mis++; $display("FAIL rerun_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (int'(bus0.err_code) !== e.err || int'(bus0.pass) !== e.pass) begin n_mis++; $display("FAIL rerun_verdict got err=%0d pass=%0d want err=%0d pass=%0d", bus0.err_code, bus0.pass, e.err, e.pass); end
      n_cmp++; if (int'(bus0.cycle_count) !== e.cnt) begin n_mis++; $display("FAIL rerun_cnt got %0d want %0d", bus0.cycle_count, e.cnt); end
      n_cmp++; if (obs_q.size() !== exp_addr_q.size()) begin n_mis++; $display("FAIL rerun_nreads got %0d want %0d", obs_q.size(), exp_addr_q.size()); end
      first = (obs_q.size() > 0) ? obs_q[0].stamp : 0;
      for (int k = 0; exp_addr_q.size() > 0 && obs_q.size() > 0; k++) begin
         ea = exp_addr_q.pop_front();
         o  = obs_q.pop_front();
         n_cmp++; if (o.addr !== ea || o.stamp !== first + k) begin n_mis++; $display("FAIL rerun_read[%0d] got addr=%0d cyc=%0d want addr=%0d cyc=%0d", k, o.addr, o.stamp, ea, first + k); end
      end
      exp_addr_q.delete();
   endtask

   initial begin
      bus0.mem_rd_data  = 32'd0;
      bus_s.mem_rd_data = 32'd0;
      bus_u.mem_rd_data = 32'd0;
      test_reset();
      test_sorted();
      test_unsorted();
      test_overflow();
      test_missing_ovf();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
